// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: the pending-store entry record and size defaults.
package store_buffer_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int DW_DEFAULT    = 32;

    typedef struct packed {
        logic [DW_DEFAULT-1:0] addr;
        logic [DW_DEFAULT-1:0] data;
        logic                  valid;
    } sb_entry_t;

endpackage

// File: rtl/sb_entry_fifo.sv
// Circular FIFO of pending stores; exposes every slot ordered oldest-first so the
// owner can run an address match over all live entries in one cycle.
module sb_entry_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  sb_entry_t                push_entry,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output sb_entry_t                entries [DEPTH]
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t       mem_reg [DEPTH];
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [PW:0]     count_reg;
    logic [PW:0]     count_next;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[tail_reg] <= push_entry;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

    // Slot gi is the gi-th oldest entry; liveness comes from the count, not the stored flag.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [PW-1:0] idx;
        sb_entry_t     slot;
        assign idx = head_reg + PW'(gi);
        always_comb begin
            slot       = mem_reg[idx];
            slot.valid = (count_reg > (PW+1)'(gi));
        end
        assign entries[gi] = slot;
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues processor stores, drains them when loads leave the memory port free.
// Optional macro STORE_BUFFER_FWD_EN forwards matching store data to loads instead of stalling.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [DW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_en,
    input  logic [DW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          ld_stall,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    input  logic [DW-1:0] mem_rd_data,
    output logic          sb_empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    sb_entry_t     entries [DEPTH];
    sb_entry_t     push_entry;
    logic          push;
    logic          pop;
    logic          hit;
    logic          stall;
    logic [DW-1:0] hit_data;

    assign st_ready = !rst || (count < CW'(DEPTH));
    assign sb_empty = !rst || (count == '0);
    assign push     = rst && st_valid && st_ready;

    always_comb begin
        push_entry       = '0;
        push_entry.addr  = DW_DEFAULT'(st_addr);
        push_entry.data  = DW_DEFAULT'(st_data);
        push_entry.valid = 1'b1;
    end

    sb_entry_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .entries    (entries)
    );

    // Walk oldest to youngest so the last match seen is the youngest store to that word.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && ((DW'(entries[i].addr) >> 2) == (ld_addr >> 2))) begin
                hit      = 1'b1;
                hit_data = DW'(entries[i].data);
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign stall   = 1'b0;
    assign ld_data = (rst && ld_en && hit) ? hit_data : mem_rd_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^hit_data;
    assign stall      = rst && ld_en && hit;
    assign ld_data    = mem_rd_data;
`endif

    // A stalled load yields the port so the matching entries can drain out.
    assign pop      = rst && (count != '0) && (!ld_en || stall);
    assign ld_stall = stall;

    always_comb begin
        mem_wr_en   = pop;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (pop) begin
            mem_addr    = DW'(entries[0].addr);
            mem_wr_data = DW'(entries[0].data);
        end else if (ld_en) begin
            mem_addr = ld_addr;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: per-cycle vector table plus multi-cycle sequences.
// Expectations follow the STORE_BUFFER_FWD_EN setting of the build.
module tb_store_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] M = 32'hA000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid;
    logic [DW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_en;
    logic [DW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_stall;
    logic          mem_wr_en;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic          sb_empty;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_stall    (ld_stall),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .sb_empty    (sb_empty)
    );

    // Data memory model: unwritten words read as M | word index.
    logic [31:0] tbmem [64];
    logic [63:0] written = '0;
    logic [5:0]  rd_idx;
    logic [63:0] wr_log [$];

    assign rd_idx      = mem_addr[7:2];
    assign mem_rd_data = written[rd_idx] ? tbmem[rd_idx] : (M | {26'd0, rd_idx});

    always @(posedge clk) begin
        if (mem_wr_en === 1'b1) begin
            tbmem[rd_idx]   <= mem_wr_data;
            written[rd_idx] <= 1'b1;
            wr_log.push_back({mem_addr, mem_wr_data});
        end
    end

    typedef struct packed {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        le;
        logic [31:0] la;
        logic [31:0] e_ld;
        logic        e_stall;
        logic        e_ready;
        logic        e_wr;
        logic        e_empty;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vt [15];
    int   vec_count = 0;
    int   err_count = 0;

    function automatic vec_t v(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                               input logic le, input logic [31:0] la, input logic [31:0] e_ld,
                               input logic e_stall, input logic e_ready, input logic e_wr,
                               input logic e_empty, input logic [31:0] e_addr,
                               input logic [31:0] e_wdata);
        vec_t r;
        r = '{sv, sa, sd, le, la, e_ld, e_stall, e_ready, e_wr, e_empty, e_addr, e_wdata};
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic set_in(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                          input logic le, input logic [31:0] la);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_en    = le;
        ld_addr  = la;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sb_empty) break;
            next_cycle();
        end
        check(name, 128'(sb_empty), 128'(1'b1));
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;

        vt[0]  = v(1, 32'h10, 32'd1, 1, 32'h80, M | 32'd32, 0, 1, 0, 1, 32'h80, 32'h0);
        vt[1]  = v(1, 32'h14, 32'd2, 1, 32'h80, M | 32'd32, 0, 1, 0, 0, 32'h80, 32'h0);
        vt[2]  = v(1, 32'h18, 32'd3, 1, 32'h80, M | 32'd32, 0, 1, 0, 0, 32'h80, 32'h0);
        vt[3]  = v(1, 32'h1C, 32'd4, 1, 32'h80, M | 32'd32, 0, 1, 0, 0, 32'h80, 32'h0);
        vt[4]  = v(1, 32'h24, 32'd9, 1, 32'h80, M | 32'd32, 0, 0, 0, 0, 32'h80, 32'h0);
        vt[5]  = v(0, 32'h0, 32'h0, 0, 32'h0, M | 32'd4, 0, 0, 1, 0, 32'h10, 32'd1);
        vt[6]  = v(0, 32'h0, 32'h0, 0, 32'h0, M | 32'd5, 0, 1, 1, 0, 32'h14, 32'd2);
        vt[7]  = v(0, 32'h0, 32'h0, 0, 32'h0, M | 32'd6, 0, 1, 1, 0, 32'h18, 32'd3);
        vt[8]  = v(0, 32'h0, 32'h0, 0, 32'h0, M | 32'd7, 0, 1, 1, 0, 32'h1C, 32'd4);
        vt[9]  = v(0, 32'h0, 32'h0, 0, 32'h0, M, 0, 1, 0, 1, 32'h0, 32'h0);
        vt[10] = v(0, 32'h0, 32'h0, 1, 32'h10, 32'd1, 0, 1, 0, 1, 32'h10, 32'h0);
        vt[11] = v(1, 32'h44, 32'h55, 1, 32'h40, M | 32'd16, 0, 1, 0, 1, 32'h40, 32'h0);
        vt[12] = v(0, 32'h0, 32'h0, 1, 32'h40, M | 32'd16, 0, 1, 0, 0, 32'h40, 32'h0);
`ifdef STORE_BUFFER_FWD_EN
        vt[13] = v(0, 32'h0, 32'h0, 1, 32'h47, 32'h55, 0, 1, 0, 0, 32'h47, 32'h0);
        vt[14] = v(0, 32'h0, 32'h0, 0, 32'h0, M | 32'd17, 0, 1, 1, 0, 32'h44, 32'h55);
`else
        vt[13] = v(0, 32'h0, 32'h0, 1, 32'h47, M | 32'd17, 1, 1, 1, 0, 32'h44, 32'h55);
        vt[14] = v(0, 32'h0, 32'h0, 0, 32'h0, M, 0, 1, 0, 1, 32'h0, 32'h0);
`endif

        // Reset with a store and a load presented: nothing is accepted or written.
        rst = 1'b0;
        set_in(1, 32'h10, 32'hDEAD, 1, 32'h40);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 128'({st_ready, sb_empty, mem_wr_en, ld_stall, ld_data}),
              128'({1'b1, 1'b1, 1'b0, 1'b0, M | 32'd16}));
        next_cycle();
        rst = 1'b1;
        set_in(0, 32'h0, 32'h0, 0, 32'h0);
        @(negedge clk);
        check("post_reset", 128'({st_ready, sb_empty, mem_wr_en, mem_addr}),
              128'({1'b1, 1'b1, 1'b0, 32'h0}));
        next_cycle();

        for (int i = 0; i < 15; i++) begin
            set_in(vt[i].sv, vt[i].sa, vt[i].sd, vt[i].le, vt[i].la);
            @(negedge clk);
            check($sformatf("row%0d", i),
                  128'({ld_data, ld_stall, st_ready, mem_wr_en, sb_empty, mem_addr, mem_wr_data}),
                  128'({vt[i].e_ld, vt[i].e_stall, vt[i].e_ready, vt[i].e_wr, vt[i].e_empty,
                        vt[i].e_addr, vt[i].e_wdata}));
            next_cycle();
        end

        // Two stores to one word, then a held load of that word.
        wr_log.delete();
        set_in(1, 32'h20, 32'hA, 1, 32'h80);
        next_cycle();
        set_in(1, 32'h20, 32'hB, 1, 32'h80);
        next_cycle();
        set_in(0, 32'h0, 32'h0, 1, 32'h20);
`ifdef STORE_BUFFER_FWD_EN
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("fwd_hit%0d", k), 128'({ld_data, ld_stall, mem_wr_en}),
                  128'({32'hB, 1'b0, 1'b0}));
            next_cycle();
        end
        set_in(0, 32'h0, 32'h0, 0, 32'h0);
        wait_empty("fwd_drained");
`else
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!ld_stall) break;
            stalls++;
            next_cycle();
        end
        check("stall_cycles", 128'(stalls), 128'(2));
        check("stall_result", 128'({ld_data, mem_wr_en, mem_addr}),
              128'({32'hB, 1'b0, 32'h20}));
        next_cycle();
        set_in(0, 32'h0, 32'h0, 0, 32'h0);
`endif
        check("same_word_writes", 128'({wr_log.size(), wr_log[0], wr_log[1]}),
              128'({32'd2, 32'h20, 32'hA, 32'h20, 32'hB}));

        // Full buffer: a push coinciding with a drain is refused, then accepted.
        wr_log.delete();
        for (int k = 0; k < 4; k++) begin
            set_in(1, 32'h60 + 32'(4 * k), 32'h61 + 32'(k), 1, 32'h80);
            next_cycle();
        end
        set_in(1, 32'h70, 32'h77, 0, 32'h0);
        @(negedge clk);
        check("full_refuse", 128'({st_ready, mem_wr_en, mem_addr}), 128'({1'b0, 1'b1, 32'h60}));
        next_cycle();
        @(negedge clk);
        check("full_accept", 128'({st_ready, mem_wr_en, mem_addr}), 128'({1'b1, 1'b1, 32'h64}));
        next_cycle();
        set_in(0, 32'h0, 32'h0, 0, 32'h0);
        wait_empty("full_drained");
        check("full_order", 128'({wr_log.size(), wr_log[0], wr_log[4]}),
              128'({32'd5, 32'h60, 32'h61, 32'h70, 32'h77}));

        // Reset with three pending entries discards them.
        wr_log.delete();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 32'h30 + 32'(4 * k), 32'h31 + 32'(k), 1, 32'h80);
            next_cycle();
        end
        set_in(0, 32'h0, 32'h0, 0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset", 128'({mem_wr_en, st_ready, sb_empty, ld_stall}),
              128'({1'b0, 1'b1, 1'b1, 1'b0}));
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("after_reset", 128'({sb_empty, mem_wr_en}), 128'({1'b1, 1'b0}));
        repeat (4) next_cycle();
        check("no_writes_after_reset", 128'(wr_log.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
